// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_xfer_arbiter_pkg
// Shared encodings for the SPI transfer arbiter:
//   state_e           - controller state encoding (3-bit)
//   DIV2..DIV16       - master clock-divide codes
//   LSB_FIRST/MSB_FIRST - bit-order selector values
package spi_xfer_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WBACK   = 3'd4,
    ST_ABORT   = 3'd5
  } state_e;

  localparam logic [1:0] DIV2  = 2'd0;
  localparam logic [1:0] DIV4  = 2'd1;
  localparam logic [1:0] DIV8  = 2'd2;
  localparam logic [1:0] DIV16 = 2'd3;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if
// Bundles the requester-side handshake and the SPI master control/data
// signals of the arbiter.
//   slave  - arbiter view: takes requests and master status, drives
//            grants, responses, chip selects and master controls.
//   master - environment view: requesters plus the SPI master itself.
interface spi_xfer_arbiter_if #(parameter int N_REQ = 4);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [2*N_REQ-1:0] req_div;
  logic [N_REQ-1:0]   req_lsb_msb;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic               rsp_err;
  logic [N_REQ-1:0]   cs_n;
  logic               busy;
  logic               m_start;
  logic [7:0]         m_rdata;
  logic [1:0]         m_c_div;
  logic               m_lsb_msb;
  logic               m_write_back_finish;
  logic               m_rst_n;
  logic               m_ss;
  logic [7:0]         m_tdata;

  modport slave (
    input  req_valid, req_data, req_div, req_lsb_msb, m_ss, m_tdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, cs_n, busy,
           m_start, m_rdata, m_c_div, m_lsb_msb, m_write_back_finish, m_rst_n
  );

  modport master (
    output req_valid, req_data, req_div, req_lsb_msb, m_ss, m_tdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cs_n, busy,
           m_start, m_rdata, m_c_div, m_lsb_msb, m_write_back_finish, m_rst_n
  );

endinterface

// File: rtl/spi_xfer_arbiter_rr.sv
// spi_rr_arbiter
// Combinational round-robin pick: the lowest-index request at or after
// ptr (wrapping) wins.
//   req   - request vector
//   ptr   - search start index (register lives in the parent)
//   en    - grant enable; no grant when low
//   grant - one-hot grant
//   idx   - binary index of the granted requester
module spi_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
// Shares one 8-bit SPI master between N_REQ requesters, each owning one
// slave chip select. Grants round-robin, latches the winner's operands
// onto the master inputs, sequences start / ss / write_back_finish and
// returns the received byte.
// Ports:
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - spi_xfer_arbiter_if.slave (requests, responses, cs_n,
//              busy and the SPI master control/data signals)
// Build option: SPI_ARB_TIMEOUT_EN adds a watchdog on START/WAIT_LO that
// aborts the transfer, pulses the master reset and answers with rsp_err.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transfer; grant the next requester if any is valid
// ST_START   | m_start high until the master drops ss
// ST_WAIT_LO | shift in progress, wait for ss to return high
// ST_WAIT_HI | settle cycle; capture m_tdata
// ST_WBACK   | write_back_finish + rsp_valid pulse
// ST_ABORT   | watchdog abort: master reset 2 cycles, then error response
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  spi_xfer_arbiter_if.slave   bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TO_W))
  begin : g_param_check
    $error("spi_xfer_arbiter: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       c_div_q, c_div_d;
  logic             lsb_msb_q, lsb_msb_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             ss_q;
  logic             rsp_fire;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  // Down-counter: the wait state times out in the cycle it reads zero.
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      ab_q, ab_d;
`endif

  spi_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      c_div_q    <= '0;
      lsb_msb_q  <= 1'b0;
      rsp_data_q <= '0;
      ss_q       <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q       <= '0;
      ab_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rdata_q    <= rdata_d;
      c_div_q    <= c_div_d;
      lsb_msb_q  <= lsb_msb_d;
      rsp_data_q <= rsp_data_d;
      ss_q       <= bus.m_ss;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q       <= to_d;
      ab_q       <= ab_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    rdata_d    = rdata_q;
    c_div_d    = c_div_q;
    lsb_msb_d  = lsb_msb_q;
    rsp_data_d = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_d       = to_q;
    ab_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          gnt_d     = arb_idx;
          ptr_d     = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          rdata_d   = bus.req_data[{arb_idx, 3'b000} +: 8];
          c_div_d   = bus.req_div[{arb_idx, 1'b0} +: 2];
          lsb_msb_d = bus.req_lsb_msb[arb_idx];
          state_d   = ST_START;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d      = TO_LOAD;
`endif
        end
      end
      ST_START: begin
`ifdef SPI_ARB_TIMEOUT_EN
        to_d = to_q - 1'b1;
`endif
        if (!bus.m_ss) begin
          state_d = ST_WAIT_LO;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d    = TO_LOAD;
`endif
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_q == '0) state_d = ST_ABORT;
`endif
      end
      ST_WAIT_LO: begin
`ifdef SPI_ARB_TIMEOUT_EN
        to_d = to_q - 1'b1;
`endif
        if (bus.m_ss) state_d = ST_WAIT_HI;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_q == '0) state_d = ST_ABORT;
`endif
      end
      ST_WAIT_HI: begin
        rsp_data_d = bus.m_tdata;
        state_d    = ST_WBACK;
      end
      ST_WBACK: state_d = ST_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
      ST_ABORT: begin
        rsp_data_d = '0;
        ab_d       = ab_q + 1'b1;
        if (ab_q == 2'd2) begin
          ab_d    = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_fire = (state_q == ST_WBACK);
`ifdef SPI_ARB_TIMEOUT_EN
    rsp_fire = rsp_fire || (state_q == ST_ABORT && ab_q == 2'd2);
`endif
    bus.rsp_valid = '0;
    if (rsp_fire) bus.rsp_valid[gnt_q] = 1'b1;
    // cs_n follows the registered ss only for the owning slave.
    bus.cs_n = '1;
    if (state_q != ST_IDLE && state_q != ST_ABORT) bus.cs_n[gnt_q] = ss_q;
  end

  assign bus.req_ready           = arb_grant;
  assign bus.rsp_data            = rsp_data_q;
  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.m_start             = (state_q == ST_START);
  assign bus.m_rdata             = rdata_q;
  assign bus.m_c_div             = c_div_q;
  assign bus.m_lsb_msb           = lsb_msb_q;
  assign bus.m_write_back_finish = (state_q == ST_WBACK);

`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.m_rst_n = !(state_q == ST_ABORT && ab_q != 2'd2);
  assign bus.rsp_err = (state_q == ST_ABORT && ab_q == 2'd2);
`else
  assign bus.m_rst_n = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

endmodule
